mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control FSM for the MIPS cpu datapath. It sequences fetch, decode, execute, memory and writeback.
- Inputs: opcode/funct from the instruction register, ALU zero flag, and a memory ready handshake.
- Outputs: all datapath enables and mux selects, plus the ALU control code.
- It replaces ad-hoc control inside cpu and adds memory wait states and illegal-instruction halt.

Parameters:
CNT_W, 32, width of the optional performance counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC load enable (unconditional or branch-taken)
- ir_write  out  1  instruction register load
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- reg_write  out  1  register file write
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B: 00 = B register, 01 = 4, 10 = signext, 11 = signext<<2
- pc_src  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target
- alu_ctrl  out  3  ALU code: 010 add, 110 sub, 000 and, 001 or, 111 slt
- state_o  out  4  current state, for debug
- illegal  out  1  sticky illegal-instruction flag
- instr_retired  out  CNT_W  retired-instruction count
- cycle_count  out  CNT_W  active-cycle count

Behaviour:
- Moore FSM with one state register. Outputs decode combinationally from the state. Only exceptions: pc_en in BEQ (= zero) and handshake-gated signals.
- Reset (synchronous): next state FETCH; illegal and counters cleared.
- While reset is high, force pc_en, ir_write, reg_write, mem_read and mem_write to 0. Reset mid-instruction abandons it with no writes.
- Unlisted outputs are 0 and alu_ctrl=010.
- FETCH(0):
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00.
  - If mem_ready: ir_write=1, pc_en=1, go to DECODE. Otherwise hold FETCH with ir_write=0, pc_en=0.
- DECODE(1):
  - alu_src_a=0, alu_src_b=11 (branch target into ALUOut).
  - Dispatch on opcode: 100011 or 101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode, or R-type with a funct outside {100000, 100010, 100100, 100101, 101010} -> HALT.
- MEMADR(2): alu_src_a=1, alu_src_b=10. Go to MEMRD for lw, MEMWR for sw.
- MEMRD(3): iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR(5): iord=1, mem_write=1, held continuously until mem_ready, then FETCH.
- RTYPEEX(6): alu_src_a=1, alu_src_b=00, alu_ctrl from funct -> RTYPEWB.
- RTYPEWB(7): reg_write=1, reg_dst=1 -> FETCH.
- BEQ(8): alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01, pc_en=zero -> FETCH.
- ADDIEX(9): alu_src_a=1, alu_src_b=10 -> ADDIWB.
- ADDIWB(10): reg_write=1, reg_dst=0 -> FETCH.
- JUMP(11): pc_src=10, pc_en=1 -> FETCH.
- HALT(12): all enables 0; illegal=1. Exit only by reset.
- Encodings 13–15 are unreachable; if entered, go to HALT.
- Latency with mem_ready tied high, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each low mem_ready cycle in FETCH/MEMRD/MEMWR adds one.

Optional Feature:
MC_PERF_EN
- Defined:
  - instr_retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQ, ADDIWB or JUMP.
  - cycle_count increments every cycle with reset low and state != HALT.
  - Both wrap modulo 2^CNT_W.
- Undefined: both outputs tied to 0 and no counter flops are built.

Decomposition:
- Package mc_ctrl_pkg: state encodings (0–12), opcode and funct constants, alu_ctrl codes, alu_src_b and pc_src select codes.
- One combinational sub-module, mc_alu_decoder: (aluop[1:0], funct) -> alu_ctrl plus a funct_valid flag. The FSM uses funct_valid for the DECODE illegal check.

Test Plan:
- lw (opcode 100011), mem_ready=1 -> state_o 0,1,2,3,4,0. Exactly one ir_write pulse and one reg_write pulse with mem_to_reg=1.
- sw with mem_ready low for 2 cycles in MEMWR -> mem_write held 3 cycles, iord=1 throughout, then FETCH. reg_write stays 0.
- beq with zero=1, then repeat with zero=0 -> pc_en=1 with pc_src=01 in BEQ; in the second run pc_en=0 in BEQ. Both return to FETCH after 3 cycles.
- R-type funct 101010 -> alu_ctrl=111 in RTYPEEX; reg_write=1, reg_dst=1 in RTYPEWB.
- Opcode 111111, and separately R-type funct 000111 -> HALT. illegal=1 and stays 1 for 20 cycles with all enables 0. Reset returns to FETCH with illegal=0.
- Reset asserted in MEMRD -> next cycle state_o=0; no reg_write ever asserted for that lw. With MC_PERF_EN: after lw, sw, addi, j (mem_ready=1), instr_retired=4, cycle_count=16.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, ALU control codes and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTYPEEX = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BEQ     = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_HALT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // How the FSM asks the ALU decoder for an operation.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
    } ctrl_t;

    // States whose exit back to FETCH completes an instruction.
    function automatic logic is_retiring(input state_e s);
        return (s == ST_MEMWB)   || (s == ST_MEMWR) || (s == ST_RTYPEWB) ||
               (s == ST_BEQ)     || (s == ST_ADDIWB) || (s == ST_JUMP);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decoder: maps the FSM's aluop request and the R-type funct
// field to an ALU code, and flags funct values the datapath cannot execute.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_valid_o
);

    logic [2:0] funct_alu;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        funct_alu     = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            FUNCT_ADD: funct_alu = ALU_ADD;
            FUNCT_SUB: funct_alu = ALU_SUB;
            FUNCT_AND: funct_alu = ALU_AND;
            FUNCT_OR:  funct_alu = ALU_OR;
            FUNCT_SLT: funct_alu = ALU_SLT;
            default:   funct_valid_o = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB:   alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: alu_ctrl_o = funct_alu;
            default:     alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM (Moore) with memory wait states and illegal
// instruction halt. Define MC_PERF_EN to build the retired/cycle counters.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_ctrl,
    output logic [3:0]       state_o,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] cycle_count
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl;
    logic [1:0] aluop;
    logic       funct_valid;

    mc_alu_decoder u_alu_decoder (
        .aluop_i       (aluop),
        .funct_i       (funct),
        .alu_ctrl_o    (alu_ctrl),
        .funct_valid_o (funct_valid)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        aluop   = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_src    = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_en    = 1'b1;
                    state_d       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_BRANCH;
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = funct_valid ? ST_RTYPEEX : ST_HALT;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_HALT;
                endcase
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                aluop          = ALUOP_FUNCT;
                state_d        = ST_RTYPEWB;
            end
            ST_RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_BEQ: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_en     = zero;
                aluop          = ALUOP_SUB;
                state_d        = ST_FETCH;
            end
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            // Unused encodings 13-15 fall into HALT rather than wander.
            default: state_d = ST_HALT;
        endcase
    end

    // The flag rises together with the HALT state and stays until reset.
    assign illegal_d = illegal_q | (state_d == ST_HALT);

    // Reset suppresses every side effect so an interrupted instruction writes nothing.
    assign pc_en      = ctrl.pc_en     & ~reset;
    assign ir_write   = ctrl.ir_write  & ~reset;
    assign mem_read   = ctrl.mem_read  & ~reset;
    assign mem_write  = ctrl.mem_write & ~reset;
    assign reg_write  = ctrl.reg_write & ~reset;
    assign iord       = ctrl.iord;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign state_o    = state_q;
    assign illegal    = illegal_q;

`ifdef MC_PERF_EN
    logic [CNT_W-1:0] instr_retired_q, instr_retired_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    always_comb begin
        instr_retired_d = instr_retired_q;
        cycle_count_d   = cycle_count_q;
        if (is_retiring(state_q) && (state_d == ST_FETCH))
            instr_retired_d = instr_retired_q + CNT_W'(1);
        if (state_q != ST_HALT)
            cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_retired_q <= '0;
            cycle_count_q   <= '0;
        end else begin
            instr_retired_q <= instr_retired_d;
            cycle_count_q   <= cycle_count_d;
        end
    end

    assign instr_retired = instr_retired_q;
    assign cycle_count   = cycle_count_q;
`else
    assign instr_retired = '0;
    assign cycle_count   = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: one task per scenario,
// inputs driven and outputs sampled around the falling clock edge.
module tb_mc_controller;

    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_en, ir_write, mem_read, mem_write, iord;
    logic             reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]       alu_src_b, pc_src;
    logic [2:0]       alu_ctrl;
    logic [3:0]       state_o;
    logic             illegal;
    logic [CNT_W-1:0] instr_retired, cycle_count;

    int errors = 0;
    int checks = 0;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alu_ctrl      (alu_ctrl),
        .state_o       (state_o),
        .illegal       (illegal),
        .instr_retired (instr_retired),
        .cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at a falling edge with the DUT in FETCH and reset low.
    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d illegal=%0b want state=0 illegal=0", state_o, illegal);
        end
        checks++;
        if ({pc_en, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_forced_enables: pc_en/ir/mrd/mwr/rw=%b want 00000",
                     {pc_en, ir_write, mem_read, mem_write, reg_write});
        end
        checks++;
        if (instr_retired !== '0 || cycle_count !== '0) begin
            errors++;
            $display("FAIL reset_counters: retired=%0d cycles=%0d want 0 0", instr_retired, cycle_count);
        end
        @(negedge clk);
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6];
        int n_ir, n_rw;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        n_ir = 0; n_rw = 0;
        do_reset();
        opcode = 6'b100011; funct = 6'd0; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state_o !== exp_st[i]) begin
                errors++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, exp_st[i]);
            end
            if (i < 5) begin
                if (ir_write) n_ir++;
                if (reg_write && mem_to_reg && !reg_dst) n_rw++;
            end
            if (i == 3) begin
                checks++;
                if (iord !== 1'b1 || mem_read !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_memrd_bus: iord=%0b mem_read=%0b want 1 1", iord, mem_read);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (n_ir != 1 || n_rw != 1) begin
            errors++;
            $display("FAIL lw_pulses: ir_write=%0d reg_write(mdr)=%0d want 1 1", n_ir, n_rw);
        end
    endtask

    task automatic test_sw_wait();
        int n_rw;
        n_rw = 0;
        do_reset();
        opcode = 6'b101011; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (reg_write) n_rw++;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            if (reg_write) n_rw++;
            checks++;
            if (state_o !== 4'd5 || mem_write !== 1'b1 || iord !== 1'b1) begin
                errors++;
                $display("FAIL sw_memwr[%0d]: state=%0d mem_write=%0b iord=%0b want 5 1 1",
                         i, state_o, mem_write, iord);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (state_o !== 4'd0 || n_rw != 0) begin
            errors++;
            $display("FAIL sw_done: state=%0d reg_writes=%0d want 0 0", state_o, n_rw);
        end
        @(negedge clk);
    endtask

    task automatic test_beq(input logic z);
        do_reset();
        opcode = 6'b000100; zero = z;
        // Two fetch wait cycles first.
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (state_o !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b0 || pc_en !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait[%0d]: state=%0d mrd=%0b ir=%0b pc_en=%0b want 0 1 0 0",
                         i, state_o, mem_read, ir_write, pc_en);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd1 || alu_src_b !== 2'b11) begin
            errors++;
            $display("FAIL beq_decode: state=%0d srcb=%b want 1 11", state_o, alu_src_b);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd8 || pc_en !== z || pc_src !== 2'b01 || alu_ctrl !== 3'b110) begin
            errors++;
            $display("FAIL beq_exec(zero=%0b): state=%0d pc_en=%0b pc_src=%b alu=%b want 8 %0b 01 110",
                     z, state_o, pc_en, pc_src, alu_ctrl, z);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL beq_return(zero=%0b): state=%0d want 0", z, state_o);
        end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        do_reset();
        opcode = 6'b000000; funct = 6'b101010; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd6 || alu_ctrl !== 3'b111 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
            errors++;
            $display("FAIL rtype_ex: state=%0d alu=%b a=%0b b=%b want 6 111 1 00",
                     state_o, alu_ctrl, alu_src_a, alu_src_b);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
            errors++;
            $display("FAIL rtype_wb: state=%0d rw=%0b dst=%0b m2r=%0b want 7 1 1 0",
                     state_o, reg_write, reg_dst, mem_to_reg);
        end
        @(negedge clk);
    endtask

    task automatic test_addi_jump();
        do_reset();
        opcode = 6'b001000; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd9 || alu_src_b !== 2'b10 || alu_ctrl !== 3'b010) begin
            errors++;
            $display("FAIL addi_ex: state=%0d b=%b alu=%b want 9 10 010", state_o, alu_src_b, alu_ctrl);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd10 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
            errors++;
            $display("FAIL addi_wb: state=%0d rw=%0b dst=%0b want 10 1 0", state_o, reg_write, reg_dst);
        end
        @(negedge clk);
        opcode = 6'b000010;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd11 || pc_en !== 1'b1 || pc_src !== 2'b10) begin
            errors++;
            $display("FAIL jump: state=%0d pc_en=%0b pc_src=%b want 11 1 10", state_o, pc_en, pc_src);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL jump_return: state=%0d want 0", state_o);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
        int bad;
        bad = 0;
        do_reset();
        opcode = op; funct = fn; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_decode(op=%b fn=%b): state=%0d illegal=%0b want 1 0", op, fn, state_o, illegal);
        end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (state_o !== 4'd12 || illegal !== 1'b1 ||
                {pc_en, ir_write, mem_read, mem_write, reg_write} !== 5'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL illegal_hold(op=%b fn=%b): %0d bad cycles want 0", op, fn, bad);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset: state=%0d illegal=%0b want 0 0", state_o, illegal);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_memrd();
        int n_rw;
        n_rw = 0;
        do_reset();
        opcode = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (reg_write) n_rw++;
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd3 || mem_read !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL memrd_reset_gate: state=%0d mrd=%0b rw=%0b want 3 0 0", state_o, mem_read, reg_write);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL memrd_reset_state: state=%0d want 0", state_o);
        end
        reset = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (reg_write) n_rw++;
        end
        checks++;
        if (n_rw != 0) begin
            errors++;
            $display("FAIL memrd_reset_nowrite: reg_write cycles=%0d want 0", n_rw);
        end
        @(negedge clk);
    endtask

    task automatic test_perf();
        do_reset();
        mem_ready = 1'b1;
        opcode = 6'b100011; repeat (5) @(negedge clk);
        opcode = 6'b101011; repeat (4) @(negedge clk);
        opcode = 6'b001000; repeat (4) @(negedge clk);
        opcode = 6'b000010; repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL perf_latency: state=%0d want 0 after 16 cycles", state_o);
        end
`ifdef MC_PERF_EN
        checks++;
        if (instr_retired !== 32'd4 || cycle_count !== 32'd16) begin
            errors++;
            $display("FAIL perf_counters: retired=%0d cycles=%0d want 4 16", instr_retired, cycle_count);
        end
`else
        checks++;
        if (instr_retired !== '0 || cycle_count !== '0) begin
            errors++;
            $display("FAIL perf_tied_off: retired=%0d cycles=%0d want 0 0", instr_retired, cycle_count);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_rtype();
        test_addi_jump();
        test_illegal(6'b111111, 6'b000000);
        test_illegal(6'b000000, 6'b000111);
        test_reset_in_memrd();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
